addr_routed_interconnect: RTL and testbench

- Parametrised address-routed hub between one tagged control stream (SPI minion adapter side) and N_PORTS module ports.
- Forward path: strips the address tag and delivers the payload to one port.
- Return path: round-robin arbitrates port responses into a FIFO, re-tags each response with its source address and sends it upstream.
- Port 0 is an internal loopback. Adds registered routing, fair arbitration, buffering and drop accounting.

---
 rtl/addr_routed_interconnect_pkg.sv | 16 +
 rtl/addr_routed_interconnect_rr_arbiter.sv | 46 ++++
 rtl/addr_routed_interconnect.sv | 160 ++++++++++++++++
 tb/tb_addr_routed_interconnect.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_routed_interconnect_pkg.sv
// Shared types and constants for the address-routed interconnect.
package addr_routed_interconnect_pkg;

  localparam int unsigned DROP_W = 8;

  typedef enum logic {
    FWD_EMPTY,
    FWD_FULL
  } fwd_state_t;

  // Tag width is at least one bit even for tiny port counts.
  function automatic int unsigned tag_width(input int unsigned n_ports);
    return (n_ports > 2) ? $clog2(n_ports) : 1;
  endfunction

endpackage

// File: rtl/addr_routed_interconnect_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted requester.
module rr_arbiter #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant
);

  localparam int unsigned IDX_W = $clog2(N);

  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
    return IDX_W'(v % N);
  endfunction

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    o_grant = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      w_cand = wrap_idx(32'(r_last) + off);
      if (!w_found && i_en && i_req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
    if (w_found) o_grant[w_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= '0;
    end else if (w_found) begin
      r_last <= w_idx;
    end
  end

endmodule

// File: rtl/addr_routed_interconnect.sv
// Address-routed hub: tagged upstream stream to N_PORTS ports, with a
// round-robin arbitrated, re-tagged return path through a small FIFO.
module addr_routed_interconnect
  import addr_routed_interconnect_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned N_PORTS   = 16,
  parameter int unsigned ADDR_BITS = tag_width(N_PORTS),
  parameter int unsigned RET_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           up_recv_val,
  output logic                           up_recv_rdy,
  input  logic [ADDR_BITS+BIT_WIDTH-1:0] up_recv_msg,
  output logic                           up_send_val,
  input  logic                           up_send_rdy,
  output logic [ADDR_BITS+BIT_WIDTH-1:0] up_send_msg,
  output logic [N_PORTS-1:0]             port_send_val,
  input  logic [N_PORTS-1:0]             port_send_rdy,
  output logic [N_PORTS*BIT_WIDTH-1:0]   port_send_msg,
  input  logic [N_PORTS-1:0]             port_recv_val,
  output logic [N_PORTS-1:0]             port_recv_rdy,
  input  logic [N_PORTS*BIT_WIDTH-1:0]   port_recv_msg,
  output logic [DROP_W-1:0]              drop_count
);

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [BIT_WIDTH-1:0] payload;
  } tag_msg_t;

  localparam int unsigned PTR_W = $clog2(RET_DEPTH);

  tag_msg_t             w_req;
  fwd_state_t           r_state;
  logic [ADDR_BITS-1:0] r_addr;
  logic [BIT_WIDTH-1:0] r_payload;
  logic [N_PORTS-1:0]   w_addr_hot;
  logic                 w_fwd_full;
  logic                 w_fwd_done;
  logic                 w_accept;
  logic                 w_req_in_range;
  logic [DROP_W-1:0]    r_drop;

  logic [N_PORTS-1:0]   w_arb_req;
  logic [N_PORTS-1:0]   w_grant;
  logic                 w_arb_en;

  tag_msg_t             r_mem [RET_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W:0]       r_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  tag_msg_t             w_push_msg;
  logic                 w_unused;

  assign w_req          = up_recv_msg;
  assign w_req_in_range = 32'(w_req.addr) < N_PORTS;
  assign w_fwd_full     = (r_state == FWD_FULL);
  assign w_unused       = ^{port_recv_val[0], port_recv_msg[BIT_WIDTH-1:0]};

  always_comb begin
    w_addr_hot = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (r_addr == ADDR_BITS'(i)) w_addr_hot[i] = 1'b1;
    end
  end

  // Loopback entries leave through the arbiter rather than a port handshake.
  assign w_fwd_done  = w_fwd_full &
                       (w_addr_hot[0] ? w_grant[0] : |(w_addr_hot & port_send_rdy));
  assign up_recv_rdy = reset_n & (~w_fwd_full | w_fwd_done);
  assign w_accept    = up_recv_val & up_recv_rdy;

  assign port_send_val = w_addr_hot & {{(N_PORTS-1){w_fwd_full}}, 1'b0};
  assign port_send_msg = {N_PORTS{r_payload}};
  assign drop_count    = r_drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= FWD_EMPTY;
      r_addr    <= '0;
      r_payload <= '0;
      r_drop    <= '0;
    end else begin
      if (w_accept && w_req_in_range) begin
        r_state   <= FWD_FULL;
        r_addr    <= w_req.addr;
        r_payload <= w_req.payload;
      end else if (w_fwd_done) begin
        r_state <= FWD_EMPTY;
      end
      if (w_accept && !w_req_in_range && (r_drop != '1)) begin
        r_drop <= r_drop + 1'b1;
      end
    end
  end

  always_comb begin
    w_arb_req    = port_recv_val;
    w_arb_req[0] = w_fwd_full & w_addr_hot[0];
  end

  // A pop in the same cycle frees a slot, so a full FIFO may still accept.
  assign w_arb_en      = reset_n & (~w_full | w_pop);
  assign port_recv_rdy = w_grant;

  rr_arbiter #(
    .N (N_PORTS)
  ) u_arb (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_en    (w_arb_en),
    .i_req   (w_arb_req),
    .o_grant (w_grant)
  );

  always_comb begin
    w_push_msg = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (w_grant[i]) begin
        w_push_msg.addr    = ADDR_BITS'(i);
        w_push_msg.payload = (i == 0) ? r_payload
                                      : port_recv_msg[i*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  assign w_full      = (r_count == (PTR_W+1)'(RET_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = |w_grant;
  assign w_pop       = ~w_empty & up_send_rdy;
  assign up_send_val = ~w_empty;
  assign up_send_msg = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < RET_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_msg;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_routed_interconnect.sv
// Scoreboard bench: stimulus pushes expected port/upstream messages, a
// negedge monitor pops and compares whenever the DUT completes a handshake.
module tb_addr_routed_interconnect;

  localparam int N  = 12;
  localparam int BW = 32;
  localparam int AB = 4;
  localparam int MW = AB + BW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          up_recv_val = 1'b0;
  logic          up_recv_rdy;
  logic [MW-1:0] up_recv_msg = '0;
  logic          up_send_val;
  logic          up_send_rdy = 1'b0;
  logic [MW-1:0] up_send_msg;
  logic [N-1:0]  port_send_val;
  logic [N-1:0]  port_send_rdy = '1;
  logic [N*BW-1:0] port_send_msg;
  logic [N-1:0]  port_recv_val;
  logic [N-1:0]  port_recv_rdy;
  logic [N*BW-1:0] port_recv_msg;
  logic [7:0]    drop_count;

  logic [N-1:0]  pend = '0;
  logic [N-1:0]  resp_hs;
  logic [BW-1:0] resp_data [N];
  logic          rdy_rand = 1'b0;
  logic          up_rdy_rand = 1'b0;
  logic [N-1:0]  rdy_fixed = '1;

  logic [MW-1:0] fwd_exp[$];
  logic [MW-1:0] up_exp[$];
  logic [MW-1:0] mon_e;
  int tests = 0;
  int fails = 0;
  int drop_exp = 0;
  int model_last = 0;
  int grant_cnt = 0;
  int g0;

  addr_routed_interconnect #(
    .BIT_WIDTH (BW),
    .N_PORTS   (N),
    .RET_DEPTH (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .up_recv_val   (up_recv_val),
    .up_recv_rdy   (up_recv_rdy),
    .up_recv_msg   (up_recv_msg),
    .up_send_val   (up_send_val),
    .up_send_rdy   (up_send_rdy),
    .up_send_msg   (up_send_msg),
    .port_send_val (port_send_val),
    .port_send_rdy (port_send_rdy),
    .port_send_msg (port_send_msg),
    .port_recv_val (port_recv_val),
    .port_recv_rdy (port_recv_rdy),
    .port_recv_msg (port_recv_msg),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  // Bit 0 is held high with junk data: the hub must ignore it.
  assign port_recv_val = pend | N'(1);
  always_comb begin
    port_recv_msg = '0;
    for (int i = 0; i < N; i++) port_recv_msg[i*BW +: BW] = resp_data[i];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    port_send_rdy = rdy_rand ? N'($urandom) : rdy_fixed;
    if (up_rdy_rand) up_send_rdy = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    resp_hs = port_recv_val & port_recv_rdy & ~N'(1);
    @(posedge clk);
    #1;
    pend = pend & ~resp_hs;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (port_send_val != '0)
        check("fwd_onehot", 64'({port_send_val[0], ($countones(port_send_val) == 1)}), 64'(2'b01));
      for (int i = 1; i < N; i++) begin
        if (port_send_val[i] && port_send_rdy[i]) begin
          if (fwd_exp.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL fwd_unexpected: got port %0d expected no delivery", i);
          end else begin
            mon_e = fwd_exp.pop_front();
            check("fwd_port", 64'(i), 64'(mon_e[MW-1:BW]));
            check("fwd_payload", 64'(port_send_msg[i*BW +: BW]), 64'(mon_e[BW-1:0]));
          end
        end
      end
      if (up_send_val && up_send_rdy) begin
        if (up_exp.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL ret_unexpected: got %0h expected nothing", up_send_msg);
        end else begin
          mon_e = up_exp.pop_front();
          check("ret_msg", 64'(up_send_msg), 64'(mon_e));
        end
      end
      grant_cnt += $countones(port_recv_rdy & port_recv_val);
    end
  end

  // Leaves up_recv_val high; caller must follow with another send or idle.
  task automatic send(input int addr, input logic [BW-1:0] data);
    bit hs = 1'b0;
    up_recv_val = 1'b1;
    up_recv_msg = {AB'(addr), data};
    if (addr == 0) begin
      up_exp.push_back({AB'(0), data});
      model_last = 0;
    end else if (addr < N) begin
      fwd_exp.push_back({AB'(addr), data});
    end
    for (int c = 0; c < 100 && !hs; c++) begin
      @(negedge clk);
      hs = up_recv_rdy;
      @(posedge clk);
      #1;
    end
    if (!hs) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got no accept expected accept for addr %0d", addr);
    end else if (addr >= N && drop_exp < 255) begin
      drop_exp++;
    end
  endtask

  task automatic post(input logic [N-1:0] mask, input bit rnd);
    for (int i = 1; i < N; i++) if (mask[i] && rnd) resp_data[i] = $urandom;
    pend = pend | mask;
  endtask

  // Expected grant order from the round-robin rule over a held request set.
  task automatic expect_rr(input logic [N-1:0] mask);
    logic [N-1:0] m = mask;
    int p;
    while (m != '0) begin
      for (int off = 1; off <= N; off++) begin
        p = (model_last + off) % N;
        if (m[p]) begin
          up_exp.push_back({AB'(p), resp_data[p]});
          m[p] = 1'b0;
          model_last = p;
          break;
        end
      end
    end
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((fwd_exp.size() != 0 || up_exp.size() != 0 || pend != '0) && c < 500) begin
      @(posedge clk);
      c++;
    end
    #1;
    check("drain_left", 64'(fwd_exp.size() + up_exp.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    fails++;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    resp_data[0] = 32'hBAD0_BAD0;
    for (int i = 1; i < N; i++) resp_data[i] = '0;
    #12;
    check("rst_up_recv_rdy", 64'(up_recv_rdy), 64'(0));
    check("rst_up_send_val", 64'(up_send_val), 64'(0));
    check("rst_up_send_msg", 64'(up_send_msg), 64'(0));
    check("rst_port_send_val", 64'(port_send_val), 64'(0));
    check("rst_port_recv_rdy", 64'(port_recv_rdy), 64'(0));
    check("rst_drop", 64'(drop_count), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    up_send_rdy = 1'b1;

    send(3, 32'hDEAD_BEEF);
    up_recv_val = 1'b0;
    @(negedge clk);
    check("t1_port_val", 64'(port_send_val), 64'(12'b1000));
    check("t1_port_msg", 64'(port_send_msg[3*BW +: BW]), 64'(32'hDEAD_BEEF));
    check("t1_up_recv_rdy", 64'(up_recv_rdy), 64'(1));
    @(posedge clk);
    #1;

    send(0, 32'h1234_5678);
    up_recv_val = 1'b0;
    @(negedge clk);
    check("t2_no_port_val", 64'(port_send_val), 64'(0));
    @(negedge clk);
    check("t2_up_val", 64'(up_send_val), 64'(1));
    check("t2_up_msg", 64'(up_send_msg), 64'({4'd0, 32'h1234_5678}));
    @(posedge clk);
    #1;
    wait_drain();

    rdy_rand = 1'b1;
    up_rdy_rand = 1'b1;
    for (int k = 0; k < 200; k++) begin
      send($urandom_range(0, 15), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        up_recv_val = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    send(0, $urandom);
    up_recv_val = 1'b0;
    rdy_rand = 1'b0;
    up_rdy_rand = 1'b0;
    up_send_rdy = 1'b1;
    wait_drain();
    check("rand_drop", 64'(drop_count), 64'(drop_exp));

    resp_data[2] = 32'hA;
    resp_data[5] = 32'hB;
    resp_data[9] = 32'hC;
    post(12'b0010_0010_0100, 1'b0);
    expect_rr(12'b0010_0010_0100);
    wait_drain();
    post(12'b0000_0010_0000, 1'b1);
    expect_rr(12'b0000_0010_0000);
    wait_drain();
    resp_data[2] = 32'hA;
    resp_data[5] = 32'hB;
    resp_data[9] = 32'hC;
    post(12'b0010_0010_0100, 1'b0);
    expect_rr(12'b0010_0010_0100);
    wait_drain();

    up_send_rdy = 1'b0;
    g0 = grant_cnt;
    post(12'b0100_1101_1010, 1'b1);
    expect_rr(12'b0100_1101_1010);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("full_grants", 64'(grant_cnt - g0), 64'(4));
    check("full_no_rdy", 64'(port_recv_rdy), 64'(0));
    @(posedge clk);
    #1;
    up_send_rdy = 1'b1;
    @(negedge clk);
    check("full_push_pop", 64'($countones(port_recv_rdy)), 64'(1));
    @(posedge clk);
    #1;
    wait_drain();
    check("full_total_grants", 64'(grant_cnt - g0), 64'(6));

    for (int k = 0; k < 300; k++) send(14, 32'h1);
    up_recv_val = 1'b0;
    @(negedge clk);
    check("drop_sat", 64'(drop_count), 64'(8'd255));
    check("drop_model", 64'(drop_count), 64'(drop_exp));
    @(posedge clk);
    #1;

    rdy_fixed = ~N'(12'b1_0000);
    @(posedge clk);
    #1;
    up_send_rdy = 1'b0;
    post(12'b0000_1000_0000, 1'b1);
    send(4, 32'hAAAA_5555);
    up_recv_msg = {4'd1, 32'hBBBB_0000};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_rdy", 64'(up_recv_rdy), 64'(0));
      check("stall_val", 64'(port_send_val), 64'(12'b1_0000));
    end
    check("stall_fifo", 64'(up_send_val), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_up_recv_rdy", 64'(up_recv_rdy), 64'(0));
    check("arst_up_send_val", 64'(up_send_val), 64'(0));
    check("arst_up_send_msg", 64'(up_send_msg), 64'(0));
    check("arst_port_send_val", 64'(port_send_val), 64'(0));
    check("arst_port_recv_rdy", 64'(port_recv_rdy), 64'(0));
    check("arst_drop", 64'(drop_count), 64'(0));
    fwd_exp.delete();
    up_exp.delete();
    pend = '0;
    up_recv_val = 1'b0;
    drop_exp = 0;
    model_last = 0;
    rdy_fixed = '1;
    up_send_rdy = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_rst_empty", 64'(up_send_val), 64'(0));
    check("post_rst_port", 64'(port_send_val), 64'(0));
    @(posedge clk);
    #1;
    send(2, 32'h55);
    up_recv_val = 1'b0;
    post(12'b0000_0100_0000, 1'b1);
    expect_rr(12'b0000_0100_0000);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
